// File: rtl/matrix_rx_if.sv
// matrix_rx_if: serial matrix driver lines (data, shift clock, latch, grayscale clock, row address)
interface matrix_rx_if;
  logic sdi;
  logic dclk;
  logic le;
  logic gclk;
  logic a;
  logic b;
  logic c;
  logic d;
  modport master (output sdi, dclk, le, gclk, a, b, c, d);
  modport slave (input sdi, dclk, le, gclk, a, b, c, d);
endinterface

// File: rtl/matrix_rx.sv
// matrix_rx: oversampling receiver that deserializes matrix driver traffic into a row/word capture buffer
module matrix_rx #(
  parameter int WIDTH = 48,
  parameter int WORDS = 8,
  parameter int ROWS  = 16,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  matrix_rx_if.slave       bus,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic [15:0]      gclk_per_frame,
  output logic             cmd_err,
  output logic             overflow
);
  localparam int WCW = $clog2(WORDS + 1);
  logic [7:0] in_v;
  logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WIDTH-1:0] sr_q, sr_d, rd_data_q, rd_data_d;
  logic [2:0] le_cnt_q, le_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, wc_eff;
  logic [15:0] gclk_cnt_q, gclk_cnt_d, gpf_q, gpf_d, frame_count_q, frame_count_d;
  logic frame_done_q, frame_done_d, cmd_err_q, cmd_err_d, overflow_q, overflow_d;
  logic sdi_s, le_s, dclk_rise, le_rise, le_fall, gclk_rise, row_chg;
  logic latch, vsync, bad, we;
  logic [3:0] row_s;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] mem [ROWS*WORDS];
  assign in_v = {bus.d, bus.c, bus.b, bus.a, bus.gclk, bus.le, bus.dclk, bus.sdi};
  // Edge detection, LE command decode and next-state for every register
  always_comb begin
    sdi_s = s2_q[0];
    le_s = s2_q[2];
    row_s = s2_q[7:4];
    dclk_rise = s2_q[1] & ~s3_q[1];
    le_rise = s2_q[2] & ~s3_q[2];
    le_fall = ~s2_q[2] & s3_q[2];
    gclk_rise = s2_q[3] & ~s3_q[3];
    row_chg = s2_q[7:4] != s3_q[7:4];
    latch = le_fall && le_cnt_q == 3'd1;
    vsync = le_fall && le_cnt_q == 3'd3;
    bad = le_fall && !latch && !vsync;
    wc_eff = row_chg ? '0 : word_cnt_q;
    we = latch && wc_eff < WCW'(WORDS);
    waddr = AW'(32'(row_s) * WORDS) + AW'(wc_eff);
    s1_d = in_v;
    s2_d = s1_q;
    s3_d = s2_q;
    sr_d = dclk_rise ? {sr_q[WIDTH-2:0], sdi_s} : sr_q;
    le_cnt_d = le_rise ? {2'b0, dclk_rise}
             : (dclk_rise && le_s && le_cnt_q != 3'd7) ? le_cnt_q + 3'd1 : le_cnt_q;
    word_cnt_d = vsync ? '0 : we ? wc_eff + WCW'(1) : wc_eff;
    gclk_cnt_d = vsync ? {15'b0, gclk_rise}
               : (gclk_rise && gclk_cnt_q != 16'hFFFF) ? gclk_cnt_q + 16'd1 : gclk_cnt_q;
    gpf_d = vsync ? gclk_cnt_q : gpf_q;
    frame_count_d = frame_count_q + {15'b0, vsync};
    frame_done_d = vsync;
    cmd_err_d = bad;
    overflow_d = overflow_q | (latch & ~we);
    rd_data_d = (32'(rd_addr) < ROWS * WORDS) ? mem[rd_addr] : '0;
  end
  // State registers; sync flops clear too so a level held through reset shows one edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      sr_q <= '0;
      le_cnt_q <= '0;
      word_cnt_q <= '0;
      gclk_cnt_q <= '0;
      gpf_q <= '0;
      frame_count_q <= '0;
      frame_done_q <= 1'b0;
      cmd_err_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      sr_q <= sr_d;
      le_cnt_q <= le_cnt_d;
      word_cnt_q <= word_cnt_d;
      gclk_cnt_q <= gclk_cnt_d;
      gpf_q <= gpf_d;
      frame_count_q <= frame_count_d;
      frame_done_q <= frame_done_d;
      cmd_err_q <= cmd_err_d;
      overflow_q <= overflow_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Capture buffer write port, kept reset-free so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= sr_q;
  end
  assign rd_data = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_count = frame_count_q;
  assign gclk_per_frame = gpf_q;
  assign cmd_err = cmd_err_q;
  assign overflow = overflow_q;
endmodule
